// File: rtl/glitch_pkg.sv
// Shared state encoding and default widths for the glitch sequencer.
// Pure declarations: no latency, no flow control.
package glitch_pkg;

  localparam int CNT_W_DEF = 32;
  localparam int REP_W_DEF = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_OFFSET,
    S_GLITCH,
    S_GAP,
    S_FINISH
  } state_t;

endpackage

// File: rtl/down_counter.sv
// Loadable saturating down-counter with a zero flag; load wins over enable.
// Count is visible one cycle after load/enable; it never wraps below zero.
module down_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/glitch_sequencer.sv
// Fault-injection power-switch sequencer: offset, then reps pulses of duration separated by gap.
// First pulse rises offset+1 cycles after the arm edge; arm is ignored while a sequence runs.
module glitch_sequencer
  import glitch_pkg::*;
#(
  parameter int   CNT_W        = CNT_W_DEF,
  parameter int   REP_W        = REP_W_DEF,
  parameter logic GLITCH_LEVEL = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             arm,
  input  logic             abort,
  input  logic [CNT_W-1:0] offset,
  input  logic [CNT_W-1:0] duration,
  input  logic [CNT_W-1:0] gap,
  input  logic [REP_W-1:0] reps,
  output logic             power_select,
  output logic             busy,
  output logic             done
);

  localparam logic IDLE_LEVEL = ~GLITCH_LEVEL;

  state_t           r_state;
  logic [CNT_W-1:0] r_dur;
  logic [CNT_W-1:0] r_gap;
  logic [REP_W-1:0] r_rep;
  logic             r_power_select;
  logic             r_busy;
  logic             r_done;

  logic w_off_zero, w_dur_zero, w_gap_zero;
  logic w_start, w_rise, w_fall, w_final, w_dur_nz, w_gap_nz;
  logic w_dur_load, w_gap_load;

  // w_rise marks a pulse start edge, w_fall the natural end of a non-empty pulse.
  assign w_start  = (r_state == S_IDLE) && arm && !abort;
  assign w_rise   = ((r_state == S_OFFSET) && w_off_zero) ||
                    ((r_state == S_GAP) && w_gap_zero);
  assign w_fall   = (r_state == S_GLITCH) && w_dur_zero;
  assign w_final  = (r_rep == REP_W'(1));
  assign w_dur_nz = (r_dur != '0);
  assign w_gap_nz = (r_gap != '0);

  assign w_dur_load = !abort && ((w_rise && w_dur_nz) || (w_fall && !w_final && !w_gap_nz));
  assign w_gap_load = !abort && w_gap_nz && !w_final && ((w_rise && !w_dur_nz) || w_fall);

  down_counter #(.W(CNT_W)) u_offset_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_start),
    .i_load_val (offset),
    .i_en       (r_state == S_OFFSET),
    .o_zero     (w_off_zero)
  );

  down_counter #(.W(CNT_W)) u_duration_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_dur_load),
    .i_load_val (r_dur - CNT_W'(1)),
    .i_en       (r_state == S_GLITCH),
    .o_zero     (w_dur_zero)
  );

  down_counter #(.W(CNT_W)) u_gap_cnt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_gap_load),
    .i_load_val (r_gap - CNT_W'(1)),
    .i_en       (r_state == S_GAP),
    .o_zero     (w_gap_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_power_select <= IDLE_LEVEL;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_dur          <= '0;
      r_gap          <= '0;
      r_rep          <= '0;
    end else begin
      r_done <= 1'b0;
      if (abort) begin
        r_state        <= S_IDLE;
        r_power_select <= IDLE_LEVEL;
        r_busy         <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (arm) begin
              r_dur   <= duration;
              r_gap   <= gap;
              r_rep   <= (reps == '0) ? REP_W'(1) : reps;
              r_busy  <= 1'b1;
              r_state <= S_OFFSET;
            end
          end
          S_OFFSET, S_GAP: begin
            // A zero-length pulse falls on its rise edge; with no gap the rest collapse too.
            if (w_rise) begin
              if (w_dur_nz) begin
                r_power_select <= GLITCH_LEVEL;
                r_state        <= S_GLITCH;
              end else if (w_final || !w_gap_nz) begin
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= S_FINISH;
              end else begin
                r_rep   <= r_rep - REP_W'(1);
                r_state <= S_GAP;
              end
            end
          end
          S_GLITCH: begin
            if (w_fall) begin
              if (w_final) begin
                r_power_select <= IDLE_LEVEL;
                r_done         <= 1'b1;
                r_busy         <= 1'b0;
                r_state        <= S_FINISH;
              end else begin
                r_rep <= r_rep - REP_W'(1);
                if (w_gap_nz) begin
                  r_power_select <= IDLE_LEVEL;
                  r_state        <= S_GAP;
                end
              end
            end
          end
          S_FINISH: r_state <= S_IDLE;
          default:  r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign power_select = r_power_select;
  assign busy         = r_busy;
  assign done         = r_done;

endmodule

// File: tb/tb_glitch_sequencer.sv
// Directed bench for glitch_sequencer: an edge-indexed timeline model plus literal spot checks.
// Inputs change on the falling edge; outputs are compared on the falling edge after each rising edge.
module tb_glitch_sequencer;

  localparam int   CNT_W = 32;
  localparam int   REP_W = 8;
  localparam logic GL    = 1'b1;
  localparam int   MAXC  = 2048;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             arm, abort;
  logic [CNT_W-1:0] offset, duration, gap;
  logic [REP_W-1:0] reps;
  logic             power_select, busy, done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int last_end = 0;

  // Expected post-edge outputs for rising edge number e.
  bit m_ps   [MAXC];
  bit m_busy [MAXC];
  bit m_done [MAXC];

  glitch_sequencer #(
    .CNT_W        (CNT_W),
    .REP_W        (REP_W),
    .GLITCH_LEVEL (GL)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .arm          (arm),
    .abort        (abort),
    .offset       (offset),
    .duration     (duration),
    .gap          (gap),
    .reps         (reps),
    .power_select (power_select),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void m_clear_from(int e);
    for (int i = e; i < MAXC; i++) begin
      m_ps[i]   = 1'b0;
      m_busy[i] = 1'b0;
      m_done[i] = 1'b0;
    end
  endfunction

  // Timeline from the rules: pulse i occupies [t, t+dur), next starts gap cycles after its fall.
  function automatic void m_plan(int k, int off, int dur, int gp, int rp);
    int n, t, fin;
    n   = (rp == 0) ? 1 : rp;
    t   = k + 1 + off;
    fin = t;
    for (int i = 0; i < n; i++) begin
      for (int e = t; e < t + dur; e++) m_ps[e] = 1'b1;
      fin = t + dur;
      t   = fin + gp;
    end
    for (int e = k; e < fin; e++) m_busy[e] = 1'b1;
    m_done[fin] = 1'b1;
    last_end    = fin;
  endfunction

  task automatic chk(input string nm, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s edge=%0d got=%b exp=%b", nm, cyc, got, exp);
    end
  endtask

  task automatic expect_now(input string nm, input logic ps_on, input logic b, input logic d);
    chk({nm, ".power_select"}, power_select, ps_on ? GL : ~GL);
    chk({nm, ".busy"}, busy, b);
    chk({nm, ".done"}, done, d);
  endtask

  task automatic go_to(input int e);
    int n;
    n = 0;
    while (cyc < e && n < 5000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (cyc != e) begin
      errors++;
      $display("FAIL go_to edge=%0d got=%0d exp=%0d", e, cyc, e);
    end
  endtask

  task automatic expect_at(input int e, input string nm, input logic ps_on, input logic b, input logic d);
    go_to(e);
    expect_now(nm, ps_on, b, d);
  endtask

  // Called at a falling edge: arm is sampled on the next rising edge k; inputs are then scrambled.
  task automatic arm_seq(input int off, input int dur, input int gp, input int rp, output int k);
    arm      = 1'b1;
    offset   = CNT_W'(off);
    duration = CNT_W'(dur);
    gap      = CNT_W'(gp);
    reps     = REP_W'(rp);
    k        = cyc + 1;
    m_plan(k, off, dur, gp, rp);
    @(negedge clk);
    arm      = 1'b0;
    offset   = $urandom;
    duration = $urandom;
    gap      = $urandom;
    reps     = REP_W'($urandom);
  endtask

  // Every-cycle comparison against the timeline model.
  initial begin
    forever begin
      @(negedge clk);
      if (cyc < MAXC) begin
        chk("model.power_select", power_select, m_ps[cyc] ? GL : ~GL);
        chk("model.busy", busy, m_busy[cyc]);
        chk("model.done", done, m_done[cyc]);
      end
    end
  end

  initial begin
    int k, k2;
    rst_n = 1'b0; arm = 1'b0; abort = 1'b0;
    offset = '0; duration = '0; gap = '0; reps = '0;
    #1 expect_now("reset", 1'b0, 1'b0, 1'b0);
    #1 rst_n = 1'b1;

    // Single pulse, arm sampled at edge 10.
    go_to(9);
    arm_seq(3, 2, 7, 1, k);
    expect_at(13, "single.pre", 1'b0, 1'b1, 1'b0);
    expect_at(14, "single.rise", 1'b1, 1'b1, 1'b0);
    expect_at(15, "single.hold", 1'b1, 1'b1, 1'b0);
    expect_at(16, "single.fall", 1'b0, 1'b0, 1'b1);
    expect_at(17, "single.after", 1'b0, 1'b0, 1'b0);
    go_to(18);

    // Three one-cycle pulses, gap 2.
    arm_seq(0, 1, 2, 3, k);
    expect_at(k + 1, "train.p1", 1'b1, 1'b1, 1'b0);
    expect_at(k + 2, "train.g1", 1'b0, 1'b1, 1'b0);
    expect_at(k + 4, "train.p2", 1'b1, 1'b1, 1'b0);
    expect_at(k + 7, "train.p3", 1'b1, 1'b1, 1'b0);
    expect_at(k + 8, "train.done", 1'b0, 1'b0, 1'b1);
    go_to(last_end + 2);

    // gap=0 merges two 2-cycle pulses into 4 continuous cycles.
    arm_seq(1, 2, 0, 2, k);
    expect_at(k + 2, "merge.rise", 1'b1, 1'b1, 1'b0);
    expect_at(k + 4, "merge.seam", 1'b1, 1'b1, 1'b0);
    expect_at(k + 5, "merge.last", 1'b1, 1'b1, 1'b0);
    expect_at(k + 6, "merge.done", 1'b0, 1'b0, 1'b1);
    go_to(last_end + 2);

    // Re-arm while busy is ignored.
    arm_seq(4, 3, 2, 2, k);
    go_to(k + 2);
    arm = 1'b1; offset = '0; duration = 32'd1; gap = '0; reps = 8'd1;
    @(negedge clk);
    arm = 1'b0;
    expect_at(k + 5, "rearm.p1", 1'b1, 1'b1, 1'b0);
    expect_at(k + 10, "rearm.p2", 1'b1, 1'b1, 1'b0);
    expect_at(k + 13, "rearm.done", 1'b0, 1'b0, 1'b1);
    go_to(last_end + 2);

    // arm together with abort in IDLE is ignored.
    arm = 1'b1; abort = 1'b1; offset = '0; duration = 32'd1; gap = '0; reps = 8'd1;
    k2 = cyc + 1;
    @(negedge clk);
    arm = 1'b0; abort = 1'b0;
    expect_now("armabort.edge", 1'b0, 1'b0, 1'b0);
    expect_at(k2 + 1, "armabort.next", 1'b0, 1'b0, 1'b0);
    expect_at(k2 + 2, "armabort.later", 1'b0, 1'b0, 1'b0);

    // Abort in the middle of a 100-cycle pulse, then re-arm immediately.
    arm_seq(2, 100, 0, 1, k);
    expect_at(k + 19, "abort.glitching", 1'b1, 1'b1, 1'b0);
    abort = 1'b1;
    m_clear_from(k + 20);
    @(negedge clk);
    abort = 1'b0;
    expect_now("abort.edge", 1'b0, 1'b0, 1'b0);
    arm_seq(1, 1, 1, 1, k2);
    expect_now("abort.rearm", 1'b0, 1'b1, 1'b0);
    expect_at(k2 + 2, "abort.rearm.rise", 1'b1, 1'b1, 1'b0);
    expect_at(k2 + 3, "abort.rearm.done", 1'b0, 1'b0, 1'b1);
    go_to(last_end + 2);

    // reps=0 behaves as one pulse.
    arm_seq(0, 2, 3, 0, k);
    expect_at(k + 3, "reps0.done", 1'b0, 1'b0, 1'b1);
    go_to(last_end + 2);

    // Zero-width pulse: no high level, done at k+1+offset.
    arm_seq(4, 0, 5, 1, k);
    expect_at(k + 4, "dur0.pre", 1'b0, 1'b1, 1'b0);
    expect_at(k + 5, "dur0.done", 1'b0, 1'b0, 1'b1);
    go_to(last_end + 2);

    // Zero-width pulses separated by gaps keep the gap timing.
    arm_seq(1, 0, 2, 3, k);
    expect_at(k + 6, "dur0gap.done", 1'b0, 1'b0, 1'b1);
    go_to(last_end + 2);

    // Maximum repeat count, merged into one long high.
    arm_seq(0, 1, 0, 255, k);
    expect_at(k + 128, "reps255.mid", 1'b1, 1'b1, 1'b0);
    expect_at(k + 255, "reps255.last", 1'b1, 1'b1, 1'b0);
    expect_at(k + 256, "reps255.done", 1'b0, 1'b0, 1'b1);
    go_to(last_end + 2);

    // Asynchronous reset mid-OFFSET, then arm on the first edge after release.
    arm_seq(20, 3, 1, 1, k);
    go_to(k + 5);
    #2 rst_n = 1'b0;
    m_clear_from(cyc + 1);
    #1 expect_now("async_rst", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    arm_seq(0, 1, 0, 1, k2);
    expect_now("post_rst.arm", 1'b0, 1'b1, 1'b0);
    expect_at(k2 + 1, "post_rst.rise", 1'b1, 1'b1, 1'b0);
    expect_at(k2 + 2, "post_rst.done", 1'b0, 1'b0, 1'b1);
    go_to(last_end + 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
